pc_fetch_stage: RTL and testbench

PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

---
 rtl/pc_fetch_stage.sv | 110 +++++++++++
 tb/tb_pc_fetch_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// PC generation and IF/ID pipeline register for the fetch stage.
// Handles jr/branch/jump redirects, stalls, and fetch bookkeeping.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        misaligned,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        mis_q, mis_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] tgt;
  logic        sel_jr;
  logic        sel_br;
  logic        sel_j;
  logic        redirect;

  assign pc4    = pc_q + 32'd4;
  assign br_tgt = (branch_base + branch_off) & 32'hFFFF_FFFC;
  assign j_tgt  = {pc4_q[31:28], jump_idx, 2'b00};
  assign jr_tgt = {jr_addr[31:2], 2'b00};

  // One-hot select encodes jr > branch > jump priority.
  assign sel_jr   = jr;
  assign sel_br   = branch_taken & ~jr;
  assign sel_j    = jump & ~jr & ~branch_taken;
  assign redirect = jr | branch_taken | jump;

  always_comb begin
    tgt = pc4;
    unique case (1'b1)
      sel_jr:  tgt = jr_tgt;
      sel_br:  tgt = br_tgt;
      sel_j:   tgt = j_tgt;
      default: tgt = pc4;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q | (sel_jr & (jr_addr[1:0] != 2'b00));
    if (redirect) begin
      pc_d    = tgt;
      instr_d = NOP_WORD;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc4;
      instr_d = imem_rdata;
      pc4_d   = pc4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign ifid_instr  = instr_q;
  assign ifid_pc4    = pc4_q;
  assign ifid_valid  = valid_q;
  assign misaligned  = mis_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_base;
  logic [31:0] branch_off;
  logic        jump;
  logic [25:0] jump_idx;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        misaligned;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  logic const_mem = 1'b0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis;

  always #5 clk = ~clk;

  pc_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_base(branch_base),
    .branch_off(branch_off),
    .jump(jump),
    .jump_idx(jump_idx),
    .jr(jr),
    .jr_addr(jr_addr),
    .imem_rdata(imem_rdata),
    .pc(pc),
    .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid),
    .misaligned(misaligned),
    .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a, input logic c);
    if (c) return 32'h2008_0005;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem(pc, const_mem);

  task automatic idle();
    stall = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_base = 0; branch_off = 0; jump_idx = 0; jr_addr = 0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = NOP; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using the current inputs, then clock.
  task automatic tick();
    logic [31:0] t;
    logic [31:0] s;
    if (jr) begin
      t = jr_addr & ~32'd3;
      if (jr_addr % 4 != 0) m_mis = 1;
    end else if (branch_taken) begin
      s = branch_base + branch_off;
      t = s - (s % 4);
    end else if (jump) begin
      t = (m_pc4 & 32'hF000_0000) + ({6'd0, jump_idx} * 4);
    end
    if (jr || branch_taken || jump) begin
      m_pc = t; m_instr = NOP; m_valid = 0; m_pc4 = 0;
    end else if (!stall) begin
      m_instr = mem(m_pc, const_mem);
      m_pc = m_pc + 4;
      m_pc4 = m_pc;
      m_valid = 1;
      m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    #12;
    checks++;
    if ({pc, ifid_instr, ifid_pc4, ifid_valid, misaligned, fetch_count}
        !== {32'd0, NOP, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset: got pc=%h instr=%h pc4=%h v=%b mis=%b cnt=%0d",
               pc, ifid_instr, ifid_pc4, ifid_valid, misaligned, fetch_count);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    const_mem = 1;
    // The release edge above already fetched once; restart cleanly.
    rst_n = 0; model_reset(); #2; rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 4 * i;
      checks++;
      if (pc !== exp_pc || ifid_pc4 !== exp_pc || ifid_instr !== 32'h2008_0005
          || ifid_valid !== 1'b1 || fetch_count !== i) begin
        errors++;
        $display("FAIL seq%0d: got pc=%h pc4=%h instr=%h v=%b cnt=%0d exp pc=%h",
                 i, pc, ifid_pc4, ifid_instr, ifid_valid, fetch_count, exp_pc);
      end
    end
    const_mem = 0;
  endtask

  task automatic test_branch();
    logic [31:0] cnt0;
    jr = 1; jr_addr = 32'h40;
    tick();
    idle();
    cnt0 = fetch_count;
    branch_taken = 1; branch_base = 32'h3C; branch_off = 32'hFFFF_FFF0;
    tick();
    idle();
    checks++;
    if (pc !== 32'h2C || ifid_valid !== 1'b0 || ifid_instr !== NOP
        || ifid_pc4 !== 0 || fetch_count !== cnt0 || fetch_count !== m_cnt) begin
      errors++;
      $display("FAIL branch: got pc=%h v=%b instr=%h cnt=%0d exp pc=0000002c cnt=%0d",
               pc, ifid_valid, ifid_instr, fetch_count, m_cnt);
    end
  endtask

  task automatic test_jr_priority();
    jr = 1; branch_taken = 1; jump = 1;
    jr_addr = 32'h0000_1002; branch_base = 32'h100; branch_off = 32'h8;
    jump_idx = 26'h33;
    tick();
    idle();
    checks++;
    if (pc !== 32'h1000 || misaligned !== 1'b1) begin
      errors++;
      $display("FAIL jr_prio: got pc=%h mis=%b exp pc=00001000 mis=1",
               pc, misaligned);
    end
    repeat (10) tick();
    checks++;
    if (misaligned !== 1'b1 || pc !== 32'h1028 || pc !== m_pc
        || ifid_instr !== m_instr) begin
      errors++;
      $display("FAIL jr_sticky: got mis=%b pc=%h instr=%h exp mis=1 pc=00001028 instr=%h",
               misaligned, pc, ifid_instr, m_instr);
    end
  endtask

  task automatic test_stall_jump();
    logic [31:0] p0, i0, q0, c0;
    logic v0;
    jr = 1; jr_addr = 32'h1C;
    tick();
    idle();
    tick();
    p0 = pc; i0 = ifid_instr; q0 = ifid_pc4; v0 = ifid_valid; c0 = fetch_count;
    checks++;
    if (pc !== 32'h20 || ifid_pc4 !== 32'h20 || ifid_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_stall: got pc=%h pc4=%h v=%b exp pc=00000020 pc4=00000020 v=1",
               pc, ifid_pc4, ifid_valid);
    end
    stall = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count}
          !== {p0, i0, q0, v0, c0}) begin
        errors++;
        $display("FAIL stall%0d: got pc=%h instr=%h pc4=%h v=%b cnt=%0d exp pc=%h cnt=%0d",
                 k, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count, p0, c0);
      end
    end
    jump = 1; jump_idx = 26'h10;
    tick();
    idle();
    checks++;
    if (pc !== 32'h40 || ifid_valid !== 1'b0 || fetch_count !== c0) begin
      errors++;
      $display("FAIL stall_jump: got pc=%h v=%b cnt=%0d exp pc=00000040 v=0 cnt=%0d",
               pc, ifid_valid, fetch_count, c0);
    end
    tick();
    tick();
    checks++;
    if (pc !== 32'h48 || ifid_pc4 !== 32'h48 || ifid_instr !== mem(32'h44, 1'b0)) begin
      errors++;
      $display("FAIL redirect_lat: got pc=%h pc4=%h instr=%h exp pc=00000048 pc4=00000048",
               pc, ifid_pc4, ifid_instr);
    end
  endtask

  task automatic test_wrap();
    jr = 1; jr_addr = 32'hFFFF_FFFC;
    tick();
    idle();
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_setup: got pc=%h exp fffffffc", pc);
    end
    tick();
    checks++;
    if (pc !== 0 || ifid_pc4 !== 0 || ifid_valid !== 1'b1
        || ifid_instr !== mem(32'hFFFF_FFFC, 1'b0)) begin
      errors++;
      $display("FAIL wrap: got pc=%h pc4=%h v=%b instr=%h exp pc=0 pc4=0 v=1",
               pc, ifid_pc4, ifid_valid, ifid_instr);
    end
    jump = 1; jump_idx = 26'h3FF_FFFF;
    tick();
    idle();
    checks++;
    if (pc !== 32'h0FFF_FFFC) begin
      errors++;
      $display("FAIL jump_hi: got pc=%h exp 0ffffffc", pc);
    end
  endtask

  task automatic test_async_reset();
    tick();
    stall = 1;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if ({pc, ifid_instr, ifid_pc4, ifid_valid, misaligned, fetch_count}
        !== {32'd0, NOP, 32'd0, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL async_reset: got pc=%h instr=%h pc4=%h v=%b mis=%b cnt=%0d",
               pc, ifid_instr, ifid_pc4, ifid_valid, misaligned, fetch_count);
    end
    jr = 1; jr_addr = 32'h800;
    @(posedge clk);
    #1;
    checks++;
    if (pc !== 0 || fetch_count !== 0) begin
      errors++;
      $display("FAIL reset_override: got pc=%h cnt=%0d exp pc=0 cnt=0", pc, fetch_count);
    end
    idle();
    #2;
    rst_n = 1;
    tick();
    checks++;
    if (pc !== 4 || ifid_pc4 !== 4 || ifid_valid !== 1'b1
        || ifid_instr !== mem(0, 1'b0) || fetch_count !== 1) begin
      errors++;
      $display("FAIL post_reset: got pc=%h pc4=%h v=%b instr=%h cnt=%0d exp pc=4 cnt=1",
               pc, ifid_pc4, ifid_valid, ifid_instr, fetch_count);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      idle();
      stall        = ($urandom_range(0, 3) == 0);
      jr           = ($urandom_range(0, 9) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      branch_base  = $urandom;
      branch_off   = $urandom;
      jump_idx     = 26'($urandom);
      jr_addr      = $urandom;
      if ($urandom_range(0, 3) != 0) jr_addr[1:0] = 2'b00;
      tick();
      checks++;
      if ({pc, ifid_instr, ifid_pc4, ifid_valid, misaligned, fetch_count}
          !== {m_pc, m_instr, m_pc4, m_valid, m_mis, m_cnt} || pc[1:0] !== 2'b00) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL rand%0d: got pc=%h instr=%h pc4=%h v=%b mis=%b cnt=%0d exp pc=%h instr=%h pc4=%h v=%b mis=%b cnt=%0d",
                   n, pc, ifid_instr, ifid_pc4, ifid_valid, misaligned, fetch_count,
                   m_pc, m_instr, m_pc4, m_valid, m_mis, m_cnt);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jr_priority();
    test_stall_jump();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
